// File: rtl/cc_miss_handler.sv
// Cache line-refill engine: latches a miss, fetches the 64-byte line with one
// 8-beat INCR AXI read burst, then writes data/tag SRAM and returns the requested word.
module cc_miss_handler (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         miss_i,
  input  logic [17:0]  tag_i,
  input  logic [7:0]   index_i,
  input  logic [5:0]   offset_i,
  output logic         busy_o,
  output logic [31:0]  mem_araddr_o,
  output logic [3:0]   mem_arlen_o,
  output logic [2:0]   mem_arsize_o,
  output logic [1:0]   mem_arburst_o,
  output logic         mem_arvalid_o,
  input  logic         mem_arready_i,
  input  logic [63:0]  mem_rdata_i,
  input  logic [1:0]   mem_rresp_i,
  input  logic         mem_rlast_i,
  input  logic         mem_rvalid_i,
  output logic         mem_rready_o,
  output logic         data_wren_o,
  output logic [7:0]   data_waddr_o,
  output logic [511:0] data_wdata_o,
  output logic         tag_wren_o,
  output logic [18:0]  tag_wdata_o,
  output logic [63:0]  rdata_o,
  output logic         done_o,
  output logic         err_o
);

  localparam int unsigned TAG_W  = 18;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BEATS  = 8;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned LINE_W = DATA_W * BEATS;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_WRITE, S_ERR} state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    word_q, word_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic                err_q, err_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [TAG_W:0]      tagw_q, tagw_d;
  logic                busy_q, arvalid_q, rready_q, wren_q, done_q, errp_q;

  // Only the word select of the offset matters; byte-in-word bits are dropped.
  logic unused_off_lsb;
  assign unused_off_lsb = ^offset_i[2:0];

  // Next-state, datapath capture and registered-output decode.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    word_d  = word_q;
    beat_d  = beat_q;
    err_d   = err_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    tagw_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (miss_i) begin
          tag_d   = tag_i;
          idx_d   = index_i;
          word_d  = offset_i[OFF_W-1:3];
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_arready_i) state_d = S_FILL;
      end
      S_FILL: begin
        if (mem_rvalid_i) begin
          line_d[{beat_q, 6'b0} +: DATA_W] = mem_rdata_i;
          beat_d = beat_q + CNT_W'(1);
          // Framing error when rlast and the final slot disagree.
          err_d  = err_q | (mem_rresp_i != 2'b00)
                   | ((beat_q == CNT_W'(BEATS - 1)) != mem_rlast_i);
          if (mem_rlast_i) state_d = err_d ? S_ERR : S_WRITE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_WRITE) begin
      rdata_d = line_d[{word_q, 6'b0} +: DATA_W];
      tagw_d  = {1'b1, tag_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tag_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      line_q    <= '0;
      rdata_q   <= '0;
      tagw_q    <= '0;
      busy_q    <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wren_q    <= 1'b0;
      done_q    <= 1'b0;
      errp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      line_q    <= line_d;
      rdata_q   <= rdata_d;
      tagw_q    <= tagw_d;
      busy_q    <= (state_d != S_IDLE);
      arvalid_q <= (state_d == S_REQ);
      rready_q  <= (state_d == S_FILL);
      wren_q    <= (state_d == S_WRITE);
      done_q    <= (state_d == S_WRITE);
      errp_q    <= (state_d == S_ERR);
    end
  end

  assign busy_o        = busy_q;
  assign mem_araddr_o  = {tag_q, idx_q, OFF_W'(0)};
  assign mem_arlen_o   = 4'(BEATS - 1);
  assign mem_arsize_o  = 3'd3;
  assign mem_arburst_o = 2'b01;
  assign mem_arvalid_o = arvalid_q;
  assign mem_rready_o  = rready_q;
  assign data_wren_o   = wren_q;
  assign data_waddr_o  = idx_q;
  assign data_wdata_o  = line_q;
  assign tag_wren_o    = wren_q;
  assign tag_wdata_o   = tagw_q;
  assign rdata_o       = rdata_q;
  assign done_o        = done_q;
  assign err_o         = errp_q;

endmodule

// File: tb/tb_cc_miss_handler.sv
// Scoreboard bench for cc_miss_handler: directed refills push expected outcomes,
// a monitor pops and compares on every done/err/write strobe.
module tb_cc_miss_handler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss_i = 1'b0;
  logic [17:0]  tag_i = '0;
  logic [7:0]   index_i = '0;
  logic [5:0]   offset_i = '0;
  logic         busy_o;
  logic [31:0]  mem_araddr_o;
  logic [3:0]   mem_arlen_o;
  logic [2:0]   mem_arsize_o;
  logic [1:0]   mem_arburst_o;
  logic         mem_arvalid_o;
  logic         mem_arready_i = 1'b0;
  logic [63:0]  mem_rdata_i = '0;
  logic [1:0]   mem_rresp_i = '0;
  logic         mem_rlast_i = 1'b0;
  logic         mem_rvalid_i = 1'b0;
  logic         mem_rready_o;
  logic         data_wren_o;
  logic [7:0]   data_waddr_o;
  logic [511:0] data_wdata_o;
  logic         tag_wren_o;
  logic [18:0]  tag_wdata_o;
  logic [63:0]  rdata_o;
  logic         done_o;
  logic         err_o;

  cc_miss_handler dut (
    .clk(clk), .rst_n(rst_n), .miss_i(miss_i), .tag_i(tag_i), .index_i(index_i),
    .offset_i(offset_i), .busy_o(busy_o), .mem_araddr_o(mem_araddr_o),
    .mem_arlen_o(mem_arlen_o), .mem_arsize_o(mem_arsize_o), .mem_arburst_o(mem_arburst_o),
    .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i), .mem_rdata_i(mem_rdata_i),
    .mem_rresp_i(mem_rresp_i), .mem_rlast_i(mem_rlast_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rready_o(mem_rready_o), .data_wren_o(data_wren_o), .data_waddr_o(data_waddr_o),
    .data_wdata_o(data_wdata_o), .tag_wren_o(tag_wren_o), .tag_wdata_o(tag_wdata_o),
    .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_err;
    logic [511:0] line;
    logic [18:0]  tagw;
    logic [7:0]   idx;
    logic [63:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ar_hs  = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_val(input int k, input logic [31:0] seed);
    return (64'h1111_0000_0000_0000 * 64'(k) + 64'(k)) ^ {seed, 32'h0};
  endfunction

  always @(posedge clk) if (mem_arvalid_o && mem_arready_i) ar_hs++;

  // Monitor: every completion or write strobe must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (done_o || err_o || data_wren_o || tag_wren_o) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 512'({done_o, err_o, data_wren_o, tag_wren_o}), 512'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done", 512'(done_o), 512'(!e.is_err));
        check("err", 512'(err_o), 512'(e.is_err));
        check("data_wren", 512'(data_wren_o), 512'(!e.is_err));
        check("tag_wren", 512'(tag_wren_o), 512'(!e.is_err));
        if (!e.is_err) begin
          check("data_wdata", data_wdata_o, e.line);
          check("data_waddr", 512'(data_waddr_o), 512'(e.idx));
          check("tag_wdata", 512'(tag_wdata_o), 512'(e.tagw));
          check("rdata", 512'(rdata_o), 512'(e.rd));
        end
      end
    end
  end

  // One refill. last_at<0 means the burst is cut short (no rlast, no outcome expected).
  task automatic run_refill(input logic [17:0] tg, input logic [7:0] ix, input logic [5:0] of,
                            input int ar_dly, input bit tog, input int bad_beat,
                            input int nbeats, input int last_at, input logic [31:0] seed,
                            input bit intrude);
    exp_t e;
    logic [31:0] exp_addr;
    exp_addr = {tg, ix, 6'b0};
    if (last_at >= 0) begin
      e.is_err = (bad_beat >= 0) || (last_at != 7);
      e.line = '0;
      for (int k = 0; k < 8; k++) e.line[k*64 +: 64] = beat_val(k, seed);
      e.tagw = {1'b1, tg};
      e.idx  = ix;
      e.rd   = beat_val(int'(of[5:3]), seed);
      sb.push_back(e);
    end
    ar_hs = 0;
    @(negedge clk);
    miss_i = 1'b1; tag_i = tg; index_i = ix; offset_i = of;
    @(posedge clk); #1;
    check("arvalid_latency", 512'(mem_arvalid_o), 512'(1));
    check("araddr", 512'(mem_araddr_o), 512'(exp_addr));
    check("busy_req", 512'(busy_o), 512'(1));
    check("ar_consts", 512'({mem_arlen_o, mem_arsize_o, mem_arburst_o}), 512'({4'd7, 3'd3, 2'b01}));
    @(negedge clk);
    miss_i = 1'b0;
    for (int i = 0; i < ar_dly; i++) begin
      if (intrude && i == 0) begin
        miss_i = 1'b1; tag_i = ~tg; index_i = ~ix; offset_i = ~of;
      end
      @(posedge clk); #1;
      check("arvalid_hold", 512'(mem_arvalid_o), 512'(1));
      check("araddr_hold", 512'(mem_araddr_o), 512'(exp_addr));
      check("rready_in_req", 512'(mem_rready_o), 512'(0));
      @(negedge clk);
      miss_i = 1'b0;
    end
    mem_arready_i = 1'b1;
    @(negedge clk);
    mem_arready_i = 1'b0;
    check("ar_handshakes", 512'(ar_hs), 512'(1));
    check("arvalid_dropped", 512'(mem_arvalid_o), 512'(0));
    check("rready_fill", 512'(mem_rready_o), 512'(1));
    for (int k = 0; k < nbeats; k++) begin
      if (tog) begin
        mem_rvalid_i = 1'b0;
        @(negedge clk);
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = beat_val(k, seed);
      mem_rresp_i  = (k == bad_beat) ? 2'b10 : 2'b00;
      mem_rlast_i  = (k == last_at);
      @(posedge clk); #1;
      if (k == last_at) check("done_or_err_latency", 512'(done_o || err_o), 512'(1));
      @(negedge clk);
    end
    mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0; mem_rresp_i = 2'b00;
    if (last_at >= 0) begin
      int n;
      n = 0;
      while (busy_o && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("busy_released", 512'(busy_o), 512'(0));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 512'(busy_o), 512'(0));
    check("rst_ctrl", 512'({mem_arvalid_o, mem_rready_o, data_wren_o, tag_wren_o, done_o, err_o}), 512'(0));
    check("rst_araddr", 512'(mem_araddr_o), 512'(0));
    check("rst_consts", 512'({mem_arlen_o, mem_arsize_o, mem_arburst_o}), 512'({4'd7, 3'd3, 2'b01}));
    check("rst_line", data_wdata_o, 512'(0));
    check("rst_rdata", 512'(rdata_o), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic refill, word 3.
    run_refill(18'h2A5A5, 8'h3C, 6'h18, 0, 1'b0, -1, 8, 7, 32'h0, 1'b0);
    // AR backpressure with an illegal miss during busy.
    run_refill(18'h00123, 8'hA1, 6'h2F, 5, 1'b0, -1, 8, 7, 32'hCAFE_0001, 1'b1);
    // Gapped R channel, word 0.
    run_refill(18'h3FFFF, 8'hFF, 6'h00, 1, 1'b1, -1, 8, 7, 32'h1234_5678, 1'b0);
    // Error response on beat 4.
    run_refill(18'h15555, 8'h10, 6'h08, 0, 1'b0, 4, 8, 7, 32'h0BAD_0004, 1'b0);
    // Early rlast on beat 5.
    run_refill(18'h0AAAA, 8'h20, 6'h10, 0, 1'b0, -1, 6, 5, 32'h0BAD_0005, 1'b0);
    // rlast missing on beat 7, burst overruns to 10 beats.
    run_refill(18'h01010, 8'h30, 6'h20, 0, 1'b1, -1, 10, 9, 32'h0BAD_0007, 1'b0);

    // Reset after three beats aborts the refill silently.
    run_refill(18'h2BEEF, 8'h44, 6'h38, 0, 1'b0, -1, 3, -1, 32'hDEAD_0000, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 512'(busy_o), 512'(0));
    check("abort_ctrl", 512'({mem_arvalid_o, mem_rready_o, data_wren_o, done_o, err_o}), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_refill(18'h2BEEF, 8'h44, 6'h3F, 2, 1'b1, -1, 8, 7, 32'h5EED_0009, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 512'(sb.size()), 512'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
